// File: rtl/tick_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_sched_pkg
// Purpose  : Shared constants and types for the tick scheduler.
// Revision : 1.0
// ============================================================================
package tick_sched_pkg;

    localparam int DIV_W  = 20;
    localparam int NUM_CH = 3;

    localparam int CH_PIXEL = 0;
    localparam int CH_SCAN  = 1;
    localparam int CH_GAME  = 2;

    localparam logic [DIV_W-1:0] DEF_DIV_PIXEL = 20'd4;
    localparam logic [DIV_W-1:0] DEF_DIV_SCAN  = 20'd262144;
    localparam logic [DIV_W-1:0] DEF_DIV_GAME  = 20'd833334;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_STEP  = 2'd2
    } game_state_t;

    function automatic logic [DIV_W-1:0] default_div(input int ch);
        case (ch)
            CH_PIXEL: default_div = DEF_DIV_PIXEL;
            CH_SCAN:  default_div = DEF_DIV_SCAN;
            default:  default_div = DEF_DIV_GAME;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_sched_if
// Purpose  : Divisor-update handshake between a configuring master and the scheduler.
// Revision : 1.0
// ============================================================================
interface tick_sched_if;
    import tick_sched_pkg::*;

    logic             cfg_valid;
    logic [1:0]       cfg_sel;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (output cfg_valid, cfg_sel, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_sel, cfg_div, output cfg_ready);

endinterface
`default_nettype wire

// File: rtl/tick_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : tick_div_chan
// Purpose  : One counter/divisor channel producing a registered tick pulse.
// Revision : 1.0
// ============================================================================
module tick_div_chan
    import tick_sched_pkg::*;
#(
    parameter logic [DIV_W-1:0] RST_DIV = 20'd4
) (
    input  wire logic             mclk,
    input  wire logic             clr_n,
    input  wire logic             en,
    input  wire logic             fire,
    input  wire logic             load,
    input  wire logic [DIV_W-1:0] load_div,
    output logic                  load_ack,
    output logic                  tick
);

    localparam logic [DIV_W-1:0] C_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             w_wrap;

    assign w_wrap   = en && (r_cnt == (r_div - C_ONE));
    // A disabled channel has no wrap to wait for, so it takes the new divisor at once.
    assign load_ack = load && (w_wrap || !en);

    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
            r_div <= RST_DIV;
            tick  <= 1'b0;
        end else begin
            tick <= fire || w_wrap;
            if (fire || w_wrap) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= r_cnt + C_ONE;
            end
            if (load_ack) begin
                r_div <= load_div;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_sched.sv
`default_nettype none
// ============================================================================
// Module   : tick_sched
// Purpose  : Three clock-enable dividers with a run/pause/step game-tick channel.
// Revision : 1.0
// ============================================================================
module tick_sched
    import tick_sched_pkg::*;
(
    input  wire logic   mclk,
    input  wire logic   clr_n,
    input  wire logic   run,
    input  wire logic   step,
    tick_sched_if.slave cfg,
    output logic [2:0]  tick,
    output logic        paused,
    output logic        cfg_err
);

    game_state_t r_state;
    game_state_t w_state_nxt;
    logic        w_fire;

    logic [NUM_CH-1:0] w_en;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_load_ack;

    logic             r_pend_valid;
    logic             r_pend_done;
    logic [1:0]       r_pend_sel;
    logic [DIV_W-1:0] r_pend_div;
    logic             r_cfg_err;
    logic             w_accept;
    logic             w_bad;

    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!run) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (run) begin
                    w_state_nxt = ST_RUN;
                end else if (step) begin
                    w_state_nxt = ST_STEP;
                    w_fire      = 1'b1;
                end
            end
            ST_STEP: w_state_nxt = ST_PAUSE;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Gating on run as well stops the game tick on the very cycle run drops.
    assign w_en[CH_PIXEL] = 1'b1;
    assign w_en[CH_SCAN]  = 1'b1;
    assign w_en[CH_GAME]  = (r_state == ST_RUN) && run;

    assign w_accept = cfg.cfg_valid && !r_pend_valid;
    assign w_bad    = (cfg.cfg_sel == 2'd3) || (cfg.cfg_div == '0);

    // The slot lingers one cycle after the apply so ready reopens the cycle after the wrap.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            r_pend_valid <= 1'b0;
            r_pend_done  <= 1'b0;
            r_pend_sel   <= 2'd0;
            r_pend_div   <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            if (r_pend_done) begin
                r_pend_valid <= 1'b0;
                r_pend_done  <= 1'b0;
            end else if (|w_load_ack) begin
                r_pend_done  <= 1'b1;
            end else if (w_accept && !w_bad) begin
                r_pend_valid <= 1'b1;
                r_pend_sel   <= cfg.cfg_sel;
                r_pend_div   <= cfg.cfg_div;
            end
            if (w_accept && w_bad) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            assign w_load[i] = r_pend_valid && !r_pend_done && (r_pend_sel == 2'(i));

            tick_div_chan #(
                .RST_DIV (default_div(i))
            ) u_chan (
                .mclk     (mclk),
                .clr_n    (clr_n),
                .en       (w_en[i]),
                .fire     ((i == CH_GAME) ? w_fire : 1'b0),
                .load     (w_load[i]),
                .load_div (r_pend_div),
                .load_ack (w_load_ack[i]),
                .tick     (tick[i])
            );
        end
    endgenerate

    assign cfg.cfg_ready = !r_pend_valid;
    assign paused        = (r_state != ST_RUN);
    assign cfg_err       = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_tick_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_sched
// Purpose  : Directed self-checking bench for tick_sched.
// Revision : 1.0
// ============================================================================
module tb_tick_sched;
    import tick_sched_pkg::*;

    logic       mclk = 1'b0;
    logic       clr_n;
    logic       run;
    logic       step;
    logic [2:0] tick;
    logic       paused;
    logic       cfg_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    tick_sched_if cfg_bus ();

    tick_sched dut (
        .mclk    (mclk),
        .clr_n   (clr_n),
        .run     (run),
        .step    (step),
        .cfg     (cfg_bus),
        .tick    (tick),
        .paused  (paused),
        .cfg_err (cfg_err)
    );

    always #5 mclk = ~mclk;

    task automatic next_cycle;
        @(posedge mclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic run_lvl);
        clr_n               = 1'b0;
        run                 = run_lvl;
        step                = 1'b0;
        cfg_bus.cfg_valid   = 1'b0;
        cfg_bus.cfg_sel     = 2'd0;
        cfg_bus.cfg_div     = '0;
        repeat (3) @(posedge mclk);
        #1;
        clr_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset;
        clr_n             = 1'b0;
        run               = 1'b1;
        step              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_sel   = 2'd0;
        cfg_bus.cfg_div   = '0;
        repeat (2) @(posedge mclk);
        #1;
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_tick got=%b exp=000", tick); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused got=%b exp=0", paused); end
        checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_bus.cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_defaults;
        logic [2:0] exp;
        do_reset(1'b1);
        repeat (40) begin
            next_cycle();
            exp    = 3'b000;
            exp[0] = (cyc % 4 == 0);
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL defaults_tick cyc=%0d got=%b exp=%b", cyc, tick, exp); end
        end
    endtask

    task automatic test_cfg_div;
        logic exp_t;
        logic exp_r;
        do_reset(1'b1);
        repeat (16) begin
            next_cycle();
            exp_t = (cyc <= 8) ? (cyc % 4 == 0) : (cyc % 2 == 0);
            exp_r = !(cyc >= 6 && cyc <= 8);
            checks++;
            if (tick[0] !== exp_t) begin errors++; $display("FAIL cfgdiv_tick cyc=%0d got=%b exp=%b", cyc, tick[0], exp_t); end
            checks++;
            if (cfg_bus.cfg_ready !== exp_r) begin errors++; $display("FAIL cfgdiv_ready cyc=%0d got=%b exp=%b", cyc, cfg_bus.cfg_ready, exp_r); end
            if (cyc == 5) begin
                cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_div = 20'd2;
            end
            if (cyc == 6) cfg_bus.cfg_valid = 1'b0;
        end
    endtask

    task automatic test_div_one;
        logic exp_t;
        do_reset(1'b1);
        repeat (12) begin
            next_cycle();
            exp_t = (cyc >= 4);
            checks++;
            if (tick[0] !== exp_t) begin errors++; $display("FAIL divone_tick cyc=%0d got=%b exp=%b", cyc, tick[0], exp_t); end
            if (cyc == 1) begin
                cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_sel = 2'd0; cfg_bus.cfg_div = 20'd1;
            end
            if (cyc == 2) cfg_bus.cfg_valid = 1'b0;
        end
    endtask

    task automatic test_step_pause;
        logic exp_t;
        logic exp_p;
        logic exp_r;
        do_reset(1'b1);
        repeat (46) begin
            next_cycle();
            exp_t = (cyc == 9 || cyc == 14 || cyc == 19 || cyc == 29 ||
                     cyc == 32 || cyc == 41 || cyc == 44);
            exp_p = (cyc >= 2 && cyc <= 25) || (cyc >= 34 && cyc <= 38);
            exp_r = !(cyc == 4 || cyc == 5);
            checks++;
            if (tick[2] !== exp_t) begin errors++; $display("FAIL step_tick2 cyc=%0d got=%b exp=%b", cyc, tick[2], exp_t); end
            checks++;
            if (paused !== exp_p) begin errors++; $display("FAIL step_paused cyc=%0d got=%b exp=%b", cyc, paused, exp_p); end
            checks++;
            if (cfg_bus.cfg_ready !== exp_r) begin errors++; $display("FAIL step_ready cyc=%0d got=%b exp=%b", cyc, cfg_bus.cfg_ready, exp_r); end
            case (cyc)
                1:  run = 1'b0;
                3:  begin cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_sel = 2'd2; cfg_bus.cfg_div = 20'd3; end
                4:  cfg_bus.cfg_valid = 1'b0;
                8, 13, 18: step = 1'b1;
                9, 14, 19: step = 1'b0;
                25: begin run = 1'b1; step = 1'b1; end
                26: step = 1'b0;
                33: run = 1'b0;
                38: begin run = 1'b1; step = 1'b1; end
                39: step = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic test_cfg_err;
        logic [2:0] exp;
        logic       exp_e;
        for (int k = 0; k < 2; k++) begin
            do_reset(1'b1);
            repeat (16) begin
                next_cycle();
                exp    = 3'b000;
                exp[0] = (cyc % 4 == 0);
                exp_e  = (cyc >= 4);
                checks++;
                if (tick !== exp) begin errors++; $display("FAIL err_tick case=%0d cyc=%0d got=%b exp=%b", k, cyc, tick, exp); end
                checks++;
                if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL err_ready case=%0d cyc=%0d got=%b exp=1", k, cyc, cfg_bus.cfg_ready); end
                checks++;
                if (cfg_err !== exp_e) begin errors++; $display("FAIL err_flag case=%0d cyc=%0d got=%b exp=%b", k, cyc, cfg_err, exp_e); end
                if (cyc == 3) begin
                    cfg_bus.cfg_valid = 1'b1;
                    cfg_bus.cfg_sel   = (k == 0) ? 2'd3 : 2'd0;
                    cfg_bus.cfg_div   = (k == 0) ? 20'd2 : 20'd0;
                end
                if (cyc == 4) cfg_bus.cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_step;
        logic [2:0] exp;
        do_reset(1'b1);
        repeat (6) begin
            next_cycle();
            case (cyc)
                1: run = 1'b0;
                2: begin cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_sel = 2'd1; cfg_bus.cfg_div = 20'd7; end
                3: cfg_bus.cfg_valid = 1'b0;
                5: step = 1'b1;
                6: step = 1'b0;
                default: ;
            endcase
        end
        checks++; if (tick !== 3'b100) begin errors++; $display("FAIL midstep_pre_tick got=%b exp=100", tick); end
        checks++; if (paused !== 1'b1) begin errors++; $display("FAIL midstep_pre_paused got=%b exp=1", paused); end
        checks++; if (cfg_bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL midstep_pre_ready got=%b exp=0", cfg_bus.cfg_ready); end
        clr_n = 1'b0;
        #1;
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL midstep_rst_tick got=%b exp=000", tick); end
        checks++; if (paused !== 1'b0) begin errors++; $display("FAIL midstep_rst_paused got=%b exp=0", paused); end
        checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL midstep_rst_ready got=%b exp=1", cfg_bus.cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL midstep_rst_err got=%b exp=0", cfg_err); end
        run = 1'b1;
        repeat (2) @(posedge mclk);
        #1;
        clr_n = 1'b1;
        cyc   = 0;
        repeat (12) begin
            next_cycle();
            exp    = 3'b000;
            exp[0] = (cyc % 4 == 0);
            checks++;
            if (tick !== exp) begin errors++; $display("FAIL midstep_post_tick cyc=%0d got=%b exp=%b", cyc, tick, exp); end
            checks++;
            if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL midstep_post_ready cyc=%0d got=%b exp=1", cyc, cfg_bus.cfg_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_cfg_div();
        test_div_one();
        test_step_pause();
        test_cfg_err();
        test_reset_mid_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
